// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : RISC-V instruction fetch stage. Owns the PC, addresses a
//            same-cycle instruction ROM and presents a registered IF/ID
//            output to decode via valid/ready. Redirects reload the PC and
//            flush the fetched instruction.
// Options  : FETCH_MISALIGN_TRAP_EN - misaligned redirect targets produce a
//            single instruction-address-misaligned marker, then fetch halts
//            until the next redirect.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_inst,
  output logic              id_exc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_t;
`else
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;
`endif

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        id_valid_n;
  logic [31:0] id_pc_n;
  logic [31:0] id_inst_n;
  logic        id_exc_n;
  logic        advance;
  logic [31:0] redirect_target;
  state_t      redirect_state;

  // The ROM is word addressed; PC bits above the ROM range are ignored.
  assign rom_addr = pc[ADDR_W+1:2];

  // Decode can take a new instruction when the output slot is empty or drained.
  assign advance = !id_valid || id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misaligned targets are loaded verbatim so the trap reports the real PC.
  always_comb begin
    redirect_target = redirect_pc;
    redirect_state  = (redirect_pc[1:0] != 2'b00) ? TRAP : RUN;
  end
`else
  // Without trap support the target is silently forced to word alignment.
  always_comb begin
    redirect_target = redirect_pc & 32'hFFFF_FFFC;
    redirect_state  = RUN;
  end
`endif

  // Next-state and next-output logic; redirect outranks every state action.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    id_valid_n = id_valid;
    id_pc_n    = id_pc;
    id_inst_n  = id_inst;
    id_exc_n   = id_exc;
    if (redirect_valid) begin
      pc_n       = redirect_target;
      id_valid_n = 1'b0;
      id_inst_n  = NOP;
      id_exc_n   = 1'b0;
      state_n    = redirect_state;
    end else begin
      case (state)
        BOOT: begin
          // ROM settle cycle: nothing is fetched.
          state_n = RUN;
          if (id_valid && id_ready) id_valid_n = 1'b0;
        end
        RUN: begin
          if (advance) begin
            id_valid_n = 1'b1;
            id_pc_n    = pc;
            id_inst_n  = rom_inst;
            id_exc_n   = 1'b0;
            pc_n       = pc + 32'd4;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: begin
          // Emit one marker entry carrying the faulting PC, then stop.
          if (advance) begin
            id_valid_n = 1'b1;
            id_pc_n    = pc;
            id_inst_n  = NOP;
            id_exc_n   = 1'b1;
            state_n    = HALT;
          end
        end
        HALT: begin
          if (id_valid && id_ready) id_valid_n = 1'b0;
        end
`endif
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

  // State, PC and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_pc    <= 32'h0000_0000;
      id_inst  <= NOP;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      id_valid <= id_valid_n;
      id_pc    <= id_pc_n;
      id_inst  <= id_inst_n;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misalignment marker travels with the IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) id_exc <= 1'b0;
    else     id_exc <= id_exc_n;
  end
`else
  // No trap support: the marker is constantly clear.
  assign id_exc = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Directed self-checking bench for inst_fetch. The ROM model
//            returns its own word index (word k holds value k).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam int          ADDR_W = 11;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              id_ready;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_inst;
  logic              id_exc;

  int checks = 0;
  int passed = 0;

  // Observation vector: {valid, exc, pc, inst}
  wire [65:0] obs = {id_valid, id_exc, id_pc, id_inst};

  inst_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_exc         (id_exc)
  );

  // Combinational ROM: word k contains k.
  assign rom_inst = {{(32-ADDR_W){1'b0}}, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [65:0] e;
    repeat (2) @(negedge clk);
    e = {1'b0, 1'b0, 32'h0, NOP};
    checks++;
    if (obs !== e) $display("FAIL reset_outputs got %h exp %h", obs, e);
    else passed++;
    checks++;
    if (rom_addr !== 11'd0) $display("FAIL reset_rom_addr got %h exp %h", rom_addr, 11'd0);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic [65:0] e;
    @(negedge clk);  // after E0: BOOT, no fetch yet
    e = {1'b0, 1'b0, 32'h0, NOP};
    checks++;
    if (obs !== e) $display("FAIL boot_cycle got %h exp %h", obs, e);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = {1'b1, 1'b0, 32'(4 * k), 32'(k)};
      checks++;
      if (obs !== e) $display("FAIL fetch_seq%0d got %h exp %h", k, obs, e);
      else passed++;
    end
  endtask

  task automatic test_stall();
    logic [65:0] e;
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = {1'b1, 1'b0, 32'h8, 32'h2};
      checks++;
      if (obs !== e) $display("FAIL stall_hold%0d got %h exp %h", k, obs, e);
      else passed++;
    end
    id_ready = 1'b1;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'hC, 32'h3};
    checks++;
    if (obs !== e) $display("FAIL stall_release got %h exp %h", obs, e);
    else passed++;
  endtask

  task automatic test_redirect();
    logic [65:0] e;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h10, 32'h4};
    checks++;
    if (obs !== e) $display("FAIL pre_redirect got %h exp %h", obs, e);
    else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    e = {1'b0, 1'b0, 32'h10, NOP};
    checks++;
    if (obs !== e) $display("FAIL redirect_flush got %h exp %h", obs, e);
    else passed++;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h40, 32'd16};
    checks++;
    if (obs !== e) $display("FAIL redirect_target got %h exp %h", obs, e);
    else passed++;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h44, 32'd17};
    checks++;
    if (obs !== e) $display("FAIL redirect_next got %h exp %h", obs, e);
    else passed++;
  endtask

  task automatic test_redirect_stall();
    logic [65:0] e;
    id_ready = 1'b0;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h44, 32'd17};
    checks++;
    if (obs !== e) $display("FAIL rs_hold got %h exp %h", obs, e);
    else passed++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    e = {1'b0, 1'b0, 32'h44, NOP};
    checks++;
    if (obs !== e) $display("FAIL rs_flush got %h exp %h", obs, e);
    else passed++;
    @(negedge clk);  // slot empty, so fetch proceeds even with id_ready low
    e = {1'b1, 1'b0, 32'h100, 32'd64};
    checks++;
    if (obs !== e) $display("FAIL rs_target got %h exp %h", obs, e);
    else passed++;
    @(negedge clk);
    checks++;
    if (obs !== e) $display("FAIL rs_target_hold got %h exp %h", obs, e);
    else passed++;
    id_ready = 1'b1;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h104, 32'd65};
    checks++;
    if (obs !== e) $display("FAIL rs_resume got %h exp %h", obs, e);
    else passed++;
  endtask

  task automatic test_reset_redirect();
    logic [65:0] e;
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    e = {1'b0, 1'b0, 32'h0, NOP};
    checks++;
    if (obs !== e) $display("FAIL rstredir_outputs got %h exp %h", obs, e);
    else passed++;
    checks++;
    if (rom_addr !== 11'd0) $display("FAIL rstredir_rom_addr got %h exp %h", rom_addr, 11'd0);
    else passed++;
    @(negedge clk);
    checks++;
    if (obs !== e) $display("FAIL rstredir_boot got %h exp %h", obs, e);
    else passed++;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h0, 32'h0};
    checks++;
    if (obs !== e) $display("FAIL rstredir_first got %h exp %h", obs, e);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [65:0] e;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1FF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b0) $display("FAIL wrap_bubble got %b exp %b", id_valid, 1'b0);
    else passed++;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h1FF8, 32'h7FE};
    checks++;
    if (obs !== e) $display("FAIL wrap_1ff8 got %h exp %h", obs, e);
    else passed++;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h1FFC, 32'h7FF};
    checks++;
    if (obs !== e) $display("FAIL wrap_1ffc got %h exp %h", obs, e);
    else passed++;
    checks++;
    if (rom_addr !== 11'd0) $display("FAIL wrap_rom_addr got %h exp %h", rom_addr, 11'd0);
    else passed++;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h2000, 32'h0};
    checks++;
    if (obs !== e) $display("FAIL wrap_2000 got %h exp %h", obs, e);
    else passed++;
  endtask

  task automatic test_misalign();
    logic [65:0] e;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
    e = {1'b0, 1'b0, 32'h2000, NOP};
    checks++;
    if (obs !== e) $display("FAIL mis_bubble got %h exp %h", obs, e);
    else passed++;
`ifdef FETCH_MISALIGN_TRAP_EN
    @(negedge clk);
    e = {1'b1, 1'b1, 32'h42, NOP};
    checks++;
    if (obs !== e) $display("FAIL mis_trap got %h exp %h", obs, e);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b0) $display("FAIL mis_halt_valid%0d got %b exp %b", k, id_valid, 1'b0);
      else passed++;
      checks++;
      if (rom_addr !== 11'h10) $display("FAIL mis_halt_addr%0d got %h exp %h", k, rom_addr, 11'h10);
      else passed++;
    end
`else
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h40, 32'd16};
    checks++;
    if (obs !== e) $display("FAIL mis_aligned got %h exp %h", obs, e);
    else passed++;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h44, 32'd17};
    checks++;
    if (obs !== e) $display("FAIL mis_aligned_next got %h exp %h", obs, e);
    else passed++;
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b0) $display("FAIL mis_resume_bubble got %b exp %b", id_valid, 1'b0);
    else passed++;
    @(negedge clk);
    e = {1'b1, 1'b0, 32'h80, 32'd32};
    checks++;
    if (obs !== e) $display("FAIL mis_resume got %h exp %h", obs, e);
    else passed++;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_redirect();
    test_wrap();
    test_misalign();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the RISC-V core: owns the program counter, drives the word address of the instruction ROM, and captures the combinationally returned instruction into a registered IF/ID output. The decode stage consumes that output through a valid/ready handshake. Execute-stage redirects (branches, jumps) reload the PC and flush the fetched instruction. The block sits between the instruction ROM (address out, instruction in, same-cycle read) and decode.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; must be 4-byte aligned.
- ADDR_W, 11, ROM word-address width; the ROM holds 2^ADDR_W words.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2]; upper PC bits ignored (address wraps)
- rom_inst  in  32  instruction at rom_addr, valid in the same cycle (combinational ROM)
- redirect_valid  in  1  load redirect_pc into the PC, flush output
- redirect_pc  in  32  redirect target byte address
- id_ready  in  1  decode accepts id_* this cycle
- id_valid  out  1  id_pc/id_inst/id_exc hold a fetched instruction
- id_pc  out  32  byte address of id_inst
- id_inst  out  32  fetched instruction
- id_exc  out  1  instruction-address-misaligned marker (see Configuration)

## Operation
- States: BOOT, RUN; with macro also TRAP, HALT.
- Reset: pc=RESET_PC, state=BOOT, id_valid=0, id_pc=0, id_inst=32'h0000_0013 (NOP), id_exc=0.
- BOOT: no fetch; next state RUN. ROM settle cycle.
- RUN: advance = !id_valid || id_ready. On advance: id_valid<=1, id_pc<=pc, id_inst<=rom_inst, id_exc<=0, pc<=pc+4 (32-bit wrap).
- Not advancing: all id_* and pc hold (stall); id_* must not change while id_valid && !id_ready.
- Redirect (any state) has priority over advance: pc<=redirect_pc, id_valid<=0, id_inst<=NOP, state<=RUN (or TRAP, see Configuration). A handshake completing in the redirect cycle is not reported specially; the register is simply cleared.
- Redirect and rst together: rst wins.
- id_valid && id_ready with no advance possible (BOOT, HALT): id_valid<=0.
- rom_addr is always driven from the current pc register, in every state.

## Timing
- Reset released before edge E0: E0 BOOT->RUN; E1 first fetch, id_valid=1, id_pc=RESET_PC.
- Sustained throughput: one instruction per cycle with id_ready=1.
- Redirect sampled at edge N: id_valid=0 after N; target captured at N+1; one bubble cycle.
- Stall: instruction after a stall is pc of the stalled one +4; no instruction lost or duplicated.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 loads pc unmodified and enters TRAP. In TRAP, on advance: id_valid<=1, id_exc<=1, id_pc<=pc, id_inst<=NOP, state<=HALT. HALT: no fetch, rom_addr held, until next redirect. Aligned redirect behaves as RUN.
- Not defined: redirect_pc[1:0] forced to 2'b00; id_exc tied 0; TRAP/HALT do not exist.

## Test plan
- Reset, RESET_PC=0, ROM word k = k, id_ready=1 -> id_valid first high after E1; id_pc 0,4,8,... id_inst 0,1,2,... one per cycle.
- id_ready low for 3 cycles while id_valid=1, id_pc=8 -> id_pc/id_inst stable at 8/2; on release next outputs 12/3.
- redirect_valid=1, redirect_pc=0x40 while id_pc=0x10 valid -> next cycle id_valid=0; following cycle id_pc=0x40, id_inst=16.
- redirect while stalled and rst simultaneously with redirect -> redirect flushes stall; rst case yields pc=RESET_PC, state BOOT, id_valid=0.
- pc reaches 0x1FFC (ADDR_W=11) -> next id_pc=0x2000, rom_addr=0, id_inst=ROM word 0.
- Redirect to 0x42: with FETCH_MISALIGN_TRAP_EN -> one output id_exc=1, id_pc=0x42, id_inst=0x13, then id_valid=0 until redirect to 0x80 resumes; without -> fetch at 0x40, id_exc=0.
